// File: rtl/memory_bus_arbiter.sv
// ---------------------------------------------------------------------------
// memory_bus_arbiter
//
// Shares one external memory bus between the CPU core and a secondary master
// (DMA/loader). Each access runs IDLE -> ACCESS -> DONE -> IDLE. ACCESS lasts
// WAIT_STATES+1 cycles, so the memory strobes are high for that long. The
// core is stalled until its own access reaches DONE.
//
// Ports
//   clk        system clock, all state on rising edge
//   rst_n      asynchronous active-low reset
//   cpu_addr   core address
//   cpu_dout   core write data
//   cpu_rd     core read request (level, held until cpu_stall low)
//   cpu_wr     core write request (level, held until cpu_stall low)
//   cpu_din    read data returned to the core (registered)
//   cpu_stall  hold core phase decoder (combinational)
//   dma_req    secondary master request (level, held until dma_ack)
//   dma_we     secondary direction, 1 = write
//   dma_addr   secondary address
//   dma_dout   secondary write data
//   dma_gnt    bus currently owned by the secondary master
//   dma_ack    one-cycle completion pulse for the secondary master
//   dma_din    read data returned to the secondary master (registered)
//   mem_addr   memory address (registered)
//   mem_dout   memory write data (registered)
//   mem_din    memory read data
//   mem_rd     memory read strobe (registered)
//   mem_wr     memory write strobe (registered)
// ---------------------------------------------------------------------------
module memory_bus_arbiter #(
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_dout,
    input  logic              cpu_rd,
    input  logic              cpu_wr,
    output logic [DATA_W-1:0] cpu_din,
    output logic              cpu_stall,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_dout,
    output logic              dma_gnt,
    output logic              dma_ack,
    output logic [DATA_W-1:0] dma_din,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dout,
    input  logic [DATA_W-1:0] mem_din,
    output logic              mem_rd,
    output logic              mem_wr
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    // Legal range is 0..15, so four bits always hold the wait count.
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t            state_reg, state_next;
    logic              owner_reg, owner_next;
    logic              last_owner_reg, last_owner_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_dout_reg, mem_dout_next;
    logic              mem_rd_reg, mem_rd_next;
    logic              mem_wr_reg, mem_wr_next;
    logic [DATA_W-1:0] cpu_din_reg, cpu_din_next;
    logic [DATA_W-1:0] dma_din_reg, dma_din_next;

    logic cpu_req;
    logic pick_dma;

    assign cpu_req = cpu_rd | cpu_wr;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            owner_reg      <= OWNER_CPU;
            last_owner_reg <= OWNER_DMA;   // so the CPU wins the first tie
            cnt_reg        <= '0;
            mem_addr_reg   <= '0;
            mem_dout_reg   <= '0;
            mem_rd_reg     <= 1'b0;
            mem_wr_reg     <= 1'b0;
            cpu_din_reg    <= '0;
            dma_din_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            cnt_reg        <= cnt_next;
            mem_addr_reg   <= mem_addr_next;
            mem_dout_reg   <= mem_dout_next;
            mem_rd_reg     <= mem_rd_next;
            mem_wr_reg     <= mem_wr_next;
            cpu_din_reg    <= cpu_din_next;
            dma_din_reg    <= dma_din_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next      = state_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        cnt_next        = cnt_reg;
        mem_addr_next   = mem_addr_reg;
        mem_dout_next   = mem_dout_reg;
        mem_rd_next     = mem_rd_reg;
        mem_wr_next     = mem_wr_reg;
        cpu_din_next    = cpu_din_reg;
        dma_din_next    = dma_din_reg;
        pick_dma        = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (cpu_req || dma_req) begin
                    // On a tie, the master that did not go last is served.
                    if (cpu_req && dma_req) begin
                        pick_dma = (last_owner_reg == OWNER_CPU);
                    end else begin
                        pick_dma = dma_req;
                    end
                    owner_next = pick_dma ? OWNER_DMA : OWNER_CPU;
                    state_next = ST_ACCESS;
                    cnt_next   = WAIT_INIT;
                    if (pick_dma) begin
                        mem_addr_next = dma_addr;
                        mem_dout_next = dma_dout;
                        mem_wr_next   = dma_we;
                        mem_rd_next   = !dma_we;
                    end else begin
                        // A write wins when the core raises both strobes.
                        mem_addr_next = cpu_addr;
                        mem_dout_next = cpu_dout;
                        mem_wr_next   = cpu_wr;
                        mem_rd_next   = !cpu_wr;
                    end
                end
            end

            ST_ACCESS: begin
                if (cnt_reg != 4'd0) begin
                    cnt_next = cnt_reg - 4'd1;
                end else begin
                    state_next  = ST_DONE;
                    mem_rd_next = 1'b0;
                    mem_wr_next = 1'b0;
                    if (mem_rd_reg) begin
                        if (owner_reg == OWNER_DMA) begin
                            dma_din_next = mem_din;
                        end else begin
                            cpu_din_next = mem_din;
                        end
                    end
                end
            end

            ST_DONE: begin
                // No new grant here; the next request is taken from IDLE.
                last_owner_next = owner_reg;
                state_next      = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Outputs
    assign mem_addr  = mem_addr_reg;
    assign mem_dout  = mem_dout_reg;
    assign mem_rd    = mem_rd_reg;
    assign mem_wr    = mem_wr_reg;
    assign cpu_din   = cpu_din_reg;
    assign dma_din   = dma_din_reg;

    assign cpu_stall = cpu_req && !((state_reg == ST_DONE) && (owner_reg == OWNER_CPU));
    assign dma_gnt   = (state_reg != ST_IDLE) && (owner_reg == OWNER_DMA);
    assign dma_ack   = (state_reg == ST_DONE) && (owner_reg == OWNER_DMA);

endmodule

// File: tb/tb_memory_bus_arbiter.sv
module tb_memory_bus_arbiter;

    localparam int WS = 1;

    typedef struct {
        logic        cpu_rd;
        logic        cpu_wr;
        logic [15:0] cpu_addr;
        logic [15:0] cpu_dout;
        logic        dma_req;
        logic        dma_we;
        logic [15:0] dma_addr;
        logic [15:0] dma_dout;
        logic        exp_dma_first;
    } vec_t;

    typedef struct {
        logic        is_dma;
        logic        we;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    int checks = 0;
    int failures = 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Main DUT (one wait state)
    logic [15:0] cpu_addr, cpu_dout, cpu_din;
    logic        cpu_rd, cpu_wr, cpu_stall;
    logic        dma_req, dma_we, dma_gnt, dma_ack;
    logic [15:0] dma_addr, dma_dout, dma_din;
    logic [15:0] mem_addr, mem_dout, mem_din;
    logic        mem_rd, mem_wr;

    // Second DUT (zero wait states)
    logic [15:0] d0_cpu_addr, d0_cpu_dout, d0_cpu_din;
    logic        d0_cpu_rd, d0_cpu_wr, d0_cpu_stall;
    logic        d0_dma_req, d0_dma_we, d0_dma_gnt, d0_dma_ack;
    logic [15:0] d0_dma_addr, d0_dma_dout, d0_dma_din;
    logic [15:0] d0_mem_addr, d0_mem_dout, d0_mem_din;
    logic        d0_mem_rd, d0_mem_wr;

    function automatic logic [15:0] mem_model(input logic [15:0] a);
        return (a == 16'h1234) ? 16'hBEEF : (a ^ 16'hC3C3);
    endfunction

    assign mem_din    = mem_model(mem_addr);
    assign d0_mem_din = mem_model(d0_mem_addr);

    memory_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(WS)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr),
        .cpu_din(cpu_din), .cpu_stall(cpu_stall),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_dout(dma_dout),
        .dma_gnt(dma_gnt), .dma_ack(dma_ack), .dma_din(dma_din),
        .mem_addr(mem_addr), .mem_dout(mem_dout), .mem_din(mem_din),
        .mem_rd(mem_rd), .mem_wr(mem_wr)
    );

    memory_bus_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(d0_cpu_addr), .cpu_dout(d0_cpu_dout), .cpu_rd(d0_cpu_rd), .cpu_wr(d0_cpu_wr),
        .cpu_din(d0_cpu_din), .cpu_stall(d0_cpu_stall),
        .dma_req(d0_dma_req), .dma_we(d0_dma_we), .dma_addr(d0_dma_addr), .dma_dout(d0_dma_dout),
        .dma_gnt(d0_dma_gnt), .dma_ack(d0_dma_ack), .dma_din(d0_dma_din),
        .mem_addr(d0_mem_addr), .mem_dout(d0_mem_dout), .mem_din(d0_mem_din),
        .mem_rd(d0_mem_rd), .mem_wr(d0_mem_wr)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expectations pushed by the driver, popped on each access
    exp_t exp_q[$];
    exp_t cur;
    logic in_acc = 1'b0;
    int   slen = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_acc = 1'b0;
        end else if (mem_rd || mem_wr) begin
            if (!in_acc) begin
                in_acc = 1'b1;
                slen   = 1;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb_unexpected_access addr=0x%0h wr=%0b t=%0t", mem_addr, mem_wr, $time);
                    cur.is_dma = dma_gnt;
                    cur.we     = mem_wr;
                    cur.addr   = mem_addr;
                    cur.data   = mem_dout;
                end else begin
                    cur = exp_q.pop_front();
                    $display("access owner=%s we=%0b addr=0x%04h t=%0t",
                             cur.is_dma ? "DMA" : "CPU", cur.we, cur.addr, $time);
                    chk("sb_owner_gnt", 32'(dma_gnt), 32'(cur.is_dma));
                    chk("sb_dir_wr", 32'(mem_wr), 32'(cur.we));
                    chk("sb_dir_rd", 32'(mem_rd), 32'(!cur.we));
                    chk("sb_addr", 32'(mem_addr), 32'(cur.addr));
                    if (cur.we) chk("sb_wdata", 32'(mem_dout), 32'(cur.data));
                    if (!cur.is_dma) chk("sb_stall_busy", 32'(cpu_stall), 32'd1);
                end
            end else begin
                slen++;
                chk("sb_addr_hold", 32'(mem_addr), 32'(cur.addr));
            end
        end else if (in_acc) begin
            in_acc = 1'b0;
            chk("sb_strobe_len", 32'(slen), 32'(WS + 1));
            chk("sb_ack", 32'(dma_ack), 32'(cur.is_dma));
            if (!cur.we) chk("sb_rdata", 32'(cur.is_dma ? dma_din : cpu_din), 32'(cur.data));
            if (!cur.is_dma) chk("sb_stall_done", 32'(cpu_stall), 32'd0);
        end
    end

    function automatic exp_t cpu_exp(input vec_t v);
        exp_t e;
        e.is_dma = 1'b0;
        e.we     = v.cpu_wr;
        e.addr   = v.cpu_addr;
        e.data   = v.cpu_wr ? v.cpu_dout : mem_model(v.cpu_addr);
        return e;
    endfunction

    function automatic exp_t dma_exp(input vec_t v);
        exp_t e;
        e.is_dma = 1'b1;
        e.we     = v.dma_we;
        e.addr   = v.dma_addr;
        e.data   = v.dma_we ? v.dma_dout : mem_model(v.dma_addr);
        return e;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        logic cpu_pend, dma_pend;
        cpu_pend = v.cpu_rd | v.cpu_wr;
        dma_pend = v.dma_req;
        if (cpu_pend && dma_pend) begin
            if (v.exp_dma_first) begin
                exp_q.push_back(dma_exp(v));
                exp_q.push_back(cpu_exp(v));
            end else begin
                exp_q.push_back(cpu_exp(v));
                exp_q.push_back(dma_exp(v));
            end
        end else if (cpu_pend) begin
            exp_q.push_back(cpu_exp(v));
        end else if (dma_pend) begin
            exp_q.push_back(dma_exp(v));
        end
        cpu_rd   = v.cpu_rd;   cpu_wr   = v.cpu_wr;
        cpu_addr = v.cpu_addr; cpu_dout = v.cpu_dout;
        dma_req  = v.dma_req;  dma_we   = v.dma_we;
        dma_addr = v.dma_addr; dma_dout = v.dma_dout;
        for (int cyc = 0; cyc < 60 && (cpu_pend || dma_pend); cyc++) begin
            @(negedge clk);
            if (cpu_pend && !cpu_stall) begin
                cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_pend = 1'b0;
            end
            if (dma_pend && dma_ack) begin
                dma_req = 1'b0; dma_pend = 1'b0;
            end
        end
        chk($sformatf("vec%0d_complete", idx), {30'd0, cpu_pend, dma_pend}, 32'd0);
        cpu_rd = 1'b0; cpu_wr = 1'b0; dma_req = 1'b0;
        @(negedge clk);
        chk($sformatf("vec%0d_queue_empty", idx), 32'(exp_q.size()), 32'd0);
    endtask

    vec_t vecs[7];
    int   done_n;

    initial begin
        // cpu_rd cpu_wr cpu_addr cpu_dout dma_req dma_we dma_addr dma_dout exp_dma_first
        vecs[0] = '{1'b0, 1'b1, 16'h0010, 16'h1111, 1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[2] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b1, 16'h0300, 16'h5555, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 16'h0400, 16'h7777, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 16'h0500, 16'h0000, 1'b1, 1'b1, 16'h0600, 16'h6666, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 16'h0700, 16'h1357, 1'b1, 1'b0, 16'h0800, 16'h0000, 1'b1};
        vecs[6] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 1'b1};

        rst_n = 1'b0;
        cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_dout = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_dout = 0;
        d0_cpu_rd = 0; d0_cpu_wr = 0; d0_cpu_addr = 0; d0_cpu_dout = 0;
        d0_dma_req = 0; d0_dma_we = 0; d0_dma_addr = 0; d0_dma_dout = 0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_mem_rd", 32'(mem_rd), 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_cpu_din", 32'(cpu_din), 32'd0);
        chk("rst_dma_din", 32'(dma_din), 32'd0);
        chk("rst_gnt_ack", {30'd0, dma_gnt, dma_ack}, 32'd0);
        chk("rst_stall", 32'(cpu_stall), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Vector table: first entry is the simultaneous CPU write / DMA read from reset
        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // CPU read, one wait state, cycle-exact strobe and stall timing
        exp_q.push_back('{1'b0, 1'b0, 16'h1234, 16'hBEEF});
        cpu_addr = 16'h1234; cpu_rd = 1'b1;
        @(negedge clk);
        chk("rd_c1_strobe", 32'(mem_rd), 32'd1);
        chk("rd_c1_stall", 32'(cpu_stall), 32'd1);
        @(negedge clk);
        chk("rd_c2_strobe", 32'(mem_rd), 32'd1);
        chk("rd_c2_stall", 32'(cpu_stall), 32'd1);
        @(negedge clk);
        chk("rd_c3_strobe", 32'(mem_rd), 32'd0);
        chk("rd_c3_stall", 32'(cpu_stall), 32'd0);
        chk("rd_c3_data", 32'(cpu_din), 32'h0000BEEF);
        cpu_rd = 1'b0;
        @(negedge clk);

        // DMA write whose request is withdrawn during ACCESS
        exp_q.push_back('{1'b1, 1'b1, 16'h0A00, 16'h9999});
        dma_addr = 16'h0A00; dma_dout = 16'h9999; dma_we = 1'b1; dma_req = 1'b1;
        @(negedge clk);
        chk("wd_c1_wr", 32'(mem_wr), 32'd1);
        dma_req = 1'b0;
        @(negedge clk);
        chk("wd_c2_wr", 32'(mem_wr), 32'd1);
        @(negedge clk);
        chk("wd_c3_wr", 32'(mem_wr), 32'd0);
        chk("wd_c3_ack", 32'(dma_ack), 32'd1);
        @(negedge clk);
        chk("wd_c4_ack", 32'(dma_ack), 32'd0);

        // Reset asserted in the middle of a DMA write
        exp_q.push_back('{1'b1, 1'b1, 16'h0B00, 16'h1212});
        dma_addr = 16'h0B00; dma_dout = 16'h1212; dma_we = 1'b1; dma_req = 1'b1;
        @(negedge clk);
        chk("mr_pre_wr", 32'(mem_wr), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_async_wr", 32'(mem_wr), 32'd0);
        chk("mr_async_gnt", 32'(dma_gnt), 32'd0);
        dma_req = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 2) rst_n = 1'b1;
            chk($sformatf("mr_no_ack%0d", k), 32'(dma_ack), 32'd0);
        end

        // Both masters held: eight strictly alternating accesses, CPU first after reset
        for (int k = 0; k < 8; k++) begin
            if (k % 2 == 0) exp_q.push_back('{1'b0, 1'b0, 16'h2000, mem_model(16'h2000)});
            else            exp_q.push_back('{1'b1, 1'b1, 16'h3000, 16'h4444});
        end
        cpu_addr = 16'h2000; cpu_rd = 1'b1;
        dma_addr = 16'h3000; dma_dout = 16'h4444; dma_we = 1'b1; dma_req = 1'b1;
        done_n = 0;
        for (int cyc = 0; cyc < 200 && done_n < 8; cyc++) begin
            @(negedge clk);
            if (dma_ack || !cpu_stall) done_n++;
            if (done_n == 8) begin
                cpu_rd = 1'b0; dma_req = 1'b0;
            end
        end
        cpu_rd = 1'b0; dma_req = 1'b0;
        chk("rr_completions", 32'(done_n), 32'd8);
        @(negedge clk);
        chk("rr_queue_empty", 32'(exp_q.size()), 32'd0);

        // Zero wait states: DMA read then DMA write with one idle cycle between
        d0_dma_addr = 16'h00FF; d0_dma_we = 1'b0; d0_dma_req = 1'b1;
        @(negedge clk);
        chk("z_rd_strobe", 32'(d0_mem_rd), 32'd1);
        chk("z_rd_addr", 32'(d0_mem_addr), 32'h00FF);
        chk("z_rd_gnt", 32'(d0_dma_gnt), 32'd1);
        @(negedge clk);
        chk("z_rd_strobe_off", 32'(d0_mem_rd), 32'd0);
        chk("z_rd_ack", 32'(d0_dma_ack), 32'd1);
        chk("z_rd_data", 32'(d0_dma_din), 32'h0000C33C);
        d0_dma_addr = 16'h0100; d0_dma_dout = 16'hA5A5; d0_dma_we = 1'b1;
        @(negedge clk);
        chk("z_gap_strobes", {30'd0, d0_mem_rd, d0_mem_wr}, 32'd0);
        chk("z_gap_gnt_ack", {30'd0, d0_dma_gnt, d0_dma_ack}, 32'd0);
        @(negedge clk);
        chk("z_wr_strobe", 32'(d0_mem_wr), 32'd1);
        chk("z_wr_addr", 32'(d0_mem_addr), 32'h0100);
        chk("z_wr_data", 32'(d0_mem_dout), 32'h0000A5A5);
        @(negedge clk);
        chk("z_wr_strobe_off", 32'(d0_mem_wr), 32'd0);
        chk("z_wr_ack", 32'(d0_dma_ack), 32'd1);
        d0_dma_req = 1'b0;
        @(negedge clk);
        chk("z_ack_once", 32'(d0_dma_ack), 32'd0);

        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
